// File: rtl/program_counter_unit_if.sv
// Purpose: fetch-stage next-PC bundle, decoder/ALU/trap controls in, PC state out.
// Latency: wiring only, no storage of its own.
// Backpressure: stall travels in the bundle; the PC unit holds while it is high in RUN.
// Ports: stall/opcode/cond_jump/imm/alu_out/trap_req/mret/fault_ack drive the unit (master -> slave);
//        pc_o/pc_plus_4_o/epc_o/fault_o/fault_addr_o/state_o come back (slave -> master).
//        Counter outputs br_total_cnt_o/br_taken_cnt_o/jump_cnt_o exist only with PC_UNIT_PERF_CNT_EN.
interface program_counter_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic            stall;
  logic [6:0]      opcode;
  logic            cond_jump;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] alu_out;
  logic            trap_req;
  logic            mret;
  logic            fault_ack;

  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc_plus_4_o;
  logic [XLEN-1:0] epc_o;
  logic            fault_o;
  logic [XLEN-1:0] fault_addr_o;
  logic [1:0]      state_o;

`ifdef PC_UNIT_PERF_CNT_EN
  logic [CNT_W-1:0] br_total_cnt_o;
  logic [CNT_W-1:0] br_taken_cnt_o;
  logic [CNT_W-1:0] jump_cnt_o;

  modport master (
    output stall, opcode, cond_jump, imm, alu_out, trap_req, mret, fault_ack,
    input  pc_o, pc_plus_4_o, epc_o, fault_o, fault_addr_o, state_o,
    input  br_total_cnt_o, br_taken_cnt_o, jump_cnt_o
  );

  modport slave (
    input  stall, opcode, cond_jump, imm, alu_out, trap_req, mret, fault_ack,
    output pc_o, pc_plus_4_o, epc_o, fault_o, fault_addr_o, state_o,
    output br_total_cnt_o, br_taken_cnt_o, jump_cnt_o
  );
`else
  modport master (
    output stall, opcode, cond_jump, imm, alu_out, trap_req, mret, fault_ack,
    input  pc_o, pc_plus_4_o, epc_o, fault_o, fault_addr_o, state_o
  );

  modport slave (
    input  stall, opcode, cond_jump, imm, alu_out, trap_req, mret, fault_ack,
    output pc_o, pc_plus_4_o, epc_o, fault_o, fault_addr_o, state_o
  );
`endif
endinterface

// File: rtl/program_counter_unit.sv
// Purpose: owns the architectural PC; picks sequential/branch/JAL/JALR next PC, traps, mret, misalign fault.
// Latency: 1 cycle from sampled inputs to new pc_o; pc_plus_4_o is combinational from pc_o.
// Backpressure: stall holds all state in RUN (trap/mret not latched); in FAULT only fault_ack matters.
// Ports: clk, rst (synchronous, active-high); bus = program_counter_unit_if.slave carrying the
//        control inputs and the registered PC/EPC/fault/state outputs.
// Option: define PC_UNIT_PERF_CNT_EN to add saturating branch/jump counters (CNT_W bits each).
module program_counter_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0040_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0040_0100,
  parameter int              CNT_W        = 32
) (
  input logic                   clk,
  input logic                   rst,
  program_counter_unit_if.slave bus
);

  localparam logic [6:0] OP_B_TYPE      = 7'b110_0011;
  localparam logic [6:0] OP_J_TYPE      = 7'b110_1111;
  localparam logic [6:0] OP_I_JALR_TYPE = 7'b110_0111;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FAULT = 2'd1;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] fault_addr_q;
  logic            fault_q;
  logic [1:0]      state_q;

  logic [XLEN-1:0] pc_plus_4;
  logic [XLEN-1:0] target;
  logic            redirect;
  logic            misaligned;

  // Next-PC selection. Only redirecting targets can be misaligned; the
  // sequential path is always a multiple of 4 away from an aligned PC.
  always_comb begin
    pc_plus_4 = pc_q + XLEN'(4);
    target    = pc_plus_4;
    redirect  = 1'b0;
    case (bus.opcode)
      OP_B_TYPE: begin
        if (bus.cond_jump) begin
          target   = pc_q + bus.imm;
          redirect = 1'b1;
        end
      end
      OP_J_TYPE: begin
        target   = pc_q + bus.imm;
        redirect = 1'b1;
      end
      OP_I_JALR_TYPE: begin
        target   = {bus.alu_out[XLEN-1:1], 1'b0};
        redirect = 1'b1;
      end
      default: begin
        target   = pc_plus_4;
        redirect = 1'b0;
      end
    endcase
    misaligned = redirect && (target[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_VECTOR;
      epc_q        <= '0;
      fault_addr_q <= '0;
      fault_q      <= 1'b0;
      state_q      <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!bus.stall) begin
            if (bus.trap_req) begin
              epc_q <= pc_q;
              pc_q  <= TRAP_VECTOR;
            end else if (bus.mret) begin
              pc_q <= epc_q;
            end else if (misaligned) begin
              // PC holds on the faulting instruction; EPC records it too.
              state_q      <= ST_FAULT;
              fault_q      <= 1'b1;
              fault_addr_q <= target;
              epc_q        <= pc_q;
            end else begin
              pc_q <= target;
            end
          end
        end
        ST_FAULT: begin
          if (bus.fault_ack) begin
            pc_q    <= TRAP_VECTOR;
            fault_q <= 1'b0;
            state_q <= ST_RUN;
          end
        end
        default: begin
          fault_q <= 1'b0;
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.pc_plus_4_o  = pc_plus_4;
  assign bus.epc_o        = epc_q;
  assign bus.fault_o      = fault_q;
  assign bus.fault_addr_o = fault_addr_q;
  assign bus.state_o      = state_q;

`ifdef PC_UNIT_PERF_CNT_EN
  logic [CNT_W-1:0] br_total_q;
  logic [CNT_W-1:0] br_taken_q;
  logic [CNT_W-1:0] jump_q;
  logic             cnt_en;

  // Count only instructions that actually retire through the normal path.
  assign cnt_en = (state_q == ST_RUN) && !bus.stall && !bus.trap_req &&
                  !bus.mret && !misaligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_total_q <= '0;
      br_taken_q <= '0;
      jump_q     <= '0;
    end else if (cnt_en) begin
      if (bus.opcode == OP_B_TYPE) begin
        if (br_total_q != {CNT_W{1'b1}}) br_total_q <= br_total_q + CNT_W'(1);
        if (bus.cond_jump && (br_taken_q != {CNT_W{1'b1}})) br_taken_q <= br_taken_q + CNT_W'(1);
      end
      if ((bus.opcode == OP_J_TYPE) || (bus.opcode == OP_I_JALR_TYPE)) begin
        if (jump_q != {CNT_W{1'b1}}) jump_q <= jump_q + CNT_W'(1);
      end
    end
  end

  assign bus.br_total_cnt_o = br_total_q;
  assign bus.br_taken_cnt_o = br_taken_q;
  assign bus.jump_cnt_o     = jump_q;
`endif

endmodule

// File: tb/tb_program_counter_unit.sv
// Purpose: self-checking bench for program_counter_unit (table vectors, corner sequences, random vs model).
// Latency: checks every output #1 after each rising edge.
// Backpressure: exercises stall in RUN and its irrelevance in FAULT.
module tb_program_counter_unit;
  localparam int XLEN = 32;
`ifdef PC_UNIT_PERF_CNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 32;
`endif
  localparam logic [6:0]  B_OP    = 7'b110_0011;
  localparam logic [6:0]  J_OP    = 7'b110_1111;
  localparam logic [6:0]  JALR_OP = 7'b110_0111;
  localparam logic [6:0]  ALU_OP  = 7'b011_0011;
  localparam logic [31:0] RV      = 32'h0040_0000;
  localparam logic [31:0] TV      = 32'h0040_0100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  program_counter_unit_if #(.XLEN(XLEN), .CNT_W(CW)) bus ();

  program_counter_unit #(
    .XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic [6:0] op, input logic cj,
                       input logic [31:0] im, input logic [31:0] alu,
                       input logic tr, input logic mr, input logic ack);
    rst           = r;
    bus.stall     = s;
    bus.opcode    = op;
    bus.cond_jump = cj;
    bus.imm       = im;
    bus.alu_out   = alu;
    bus.trap_req  = tr;
    bus.mret      = mr;
    bus.fault_ack = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_epc,
                           input logic e_f, input logic [31:0] e_fa, input logic [1:0] e_st);
    chk({tag, " pc"},        bus.pc_o,               e_pc);
    chk({tag, " pc_plus_4"}, bus.pc_plus_4_o,        e_pc + 32'd4);
    chk({tag, " epc"},       bus.epc_o,              e_epc);
    chk({tag, " fault"},     32'(bus.fault_o),       32'(e_f));
    chk({tag, " fault_addr"}, bus.fault_addr_o,      e_fa);
    chk({tag, " state"},     32'(bus.state_o),       32'(e_st));
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic        r, s;
    logic [6:0]  op;
    logic        cj;
    logic [31:0] im, alu;
    logic        tr, mr, ack;
    logic [31:0] e_pc, e_epc;
    logic        e_f;
    logic [31:0] e_fa;
    logic [1:0]  e_st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic s, input logic [6:0] op, input logic cj,
                              input logic [31:0] im, input logic [31:0] alu,
                              input logic tr, input logic mr, input logic ack,
                              input logic [31:0] e_pc, input logic [31:0] e_epc,
                              input logic e_f, input logic [31:0] e_fa, input logic [1:0] e_st);
    vec_t v;
    v.r = r; v.s = s; v.op = op; v.cj = cj; v.im = im; v.alu = alu;
    v.tr = tr; v.mr = mr; v.ack = ack;
    v.e_pc = e_pc; v.e_epc = e_epc; v.e_f = e_f; v.e_fa = e_fa; v.e_st = e_st;
    return v;
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_epc, m_fa;
  logic        m_f;
  longint      m_tot, m_tkn, m_jmp;
  longint      cnt_max = (64'd1 << CW) - 1;

  task automatic model_step(input logic r, input logic s, input logic [6:0] op, input logic cj,
                            input logic [31:0] im, input logic [31:0] alu,
                            input logic tr, input logic mr, input logic ack);
    logic [31:0] tgt;
    logic        redir;
    if (r) begin
      m_pc = RV; m_epc = 0; m_fa = 0; m_f = 0;
      m_tot = 0; m_tkn = 0; m_jmp = 0;
    end else if (m_f) begin
      if (ack) begin m_pc = TV; m_f = 0; end
    end else if (s) begin
      // nothing moves
    end else if (tr) begin
      m_epc = m_pc; m_pc = TV;
    end else if (mr) begin
      m_pc = m_epc;
    end else begin
      redir = 1'b1;
      if (op == B_OP && cj)    tgt = m_pc + im;
      else if (op == J_OP)     tgt = m_pc + im;
      else if (op == JALR_OP)  tgt = alu - (alu % 2);
      else begin tgt = m_pc + 4; redir = 1'b0; end
      if (redir && (tgt % 4) != 0) begin
        m_f = 1; m_fa = tgt; m_epc = m_pc;
      end else begin
        m_pc = tgt;
        if (op == B_OP && m_tot < cnt_max) m_tot++;
        if (op == B_OP && cj && m_tkn < cnt_max) m_tkn++;
        if ((op == J_OP || op == JALR_OP) && m_jmp < cnt_max) m_jmp++;
      end
    end
  endtask

`ifdef PC_UNIT_PERF_CNT_EN
  task automatic check_cnt(input string tag, input longint e_tot, input longint e_tkn, input longint e_jmp);
    chk({tag, " br_total"}, 32'(bus.br_total_cnt_o), 32'(e_tot));
    chk({tag, " br_taken"}, 32'(bus.br_taken_cnt_o), 32'(e_tkn));
    chk({tag, " jump_cnt"}, 32'(bus.jump_cnt_o),     32'(e_jmp));
  endtask
`endif

  initial begin
    logic        r, s, cj, tr, mr, ack;
    logic [6:0]  op;
    logic [31:0] im, alu;

    //         r  s  op       cj imm            alu            tr mr ak  pc            epc           f  faddr         st
    tbl.push_back(mk(1, 0, ALU_OP, 0, 0,             0,             0, 0, 0, RV,           0,            0, 0,            0));
    tbl.push_back(mk(0, 0, ALU_OP, 0, 0,             0,             0, 0, 0, 32'h0040_0004, 0,           0, 0,            0));
    tbl.push_back(mk(0, 0, ALU_OP, 0, 0,             0,             0, 0, 0, 32'h0040_0008, 0,           0, 0,            0));
    tbl.push_back(mk(0, 0, ALU_OP, 0, 0,             0,             0, 0, 0, 32'h0040_000C, 0,           0, 0,            0));
    tbl.push_back(mk(0, 0, ALU_OP, 0, 0,             0,             0, 0, 0, 32'h0040_0010, 0,           0, 0,            0));
    tbl.push_back(mk(0, 1, B_OP,   1, 32'hFFFF_FFF8, 0,             0, 0, 0, 32'h0040_0010, 0,           0, 0,            0));
    tbl.push_back(mk(0, 1, B_OP,   1, 32'hFFFF_FFF8, 0,             1, 0, 0, 32'h0040_0010, 0,           0, 0,            0));
    tbl.push_back(mk(0, 0, B_OP,   1, 32'hFFFF_FFF8, 0,             0, 0, 0, 32'h0040_0008, 0,           0, 0,            0));
    tbl.push_back(mk(0, 0, J_OP,   0, 32'd8,         0,             0, 0, 0, 32'h0040_0010, 0,           0, 0,            0));
    tbl.push_back(mk(0, 0, B_OP,   0, 32'hFFFF_FFF8, 0,             0, 0, 0, 32'h0040_0014, 0,           0, 0,            0));
    tbl.push_back(mk(0, 0, J_OP,   0, 32'd12,        0,             0, 0, 0, 32'h0040_0020, 0,           0, 0,            0));
    tbl.push_back(mk(0, 0, JALR_OP,0, 0,             32'h0040_1001, 0, 0, 0, 32'h0040_1000, 0,           0, 0,            0));
    tbl.push_back(mk(0, 0, JALR_OP,0, 0,             32'h0040_0020, 0, 0, 0, 32'h0040_0020, 0,           0, 0,            0));
    tbl.push_back(mk(0, 0, JALR_OP,0, 0,             32'h0040_1002, 0, 0, 0, 32'h0040_0020, 32'h0040_0020, 1, 32'h0040_1002, 1));
    tbl.push_back(mk(0, 1, J_OP,   0, 32'd4,         0,             1, 1, 0, 32'h0040_0020, 32'h0040_0020, 1, 32'h0040_1002, 1));
    tbl.push_back(mk(0, 0, ALU_OP, 0, 0,             0,             0, 0, 1, TV,           32'h0040_0020, 0, 32'h0040_1002, 0));
    tbl.push_back(mk(0, 0, ALU_OP, 0, 0,             0,             0, 0, 1, 32'h0040_0104, 32'h0040_0020, 0, 32'h0040_1002, 0));
    tbl.push_back(mk(0, 0, JALR_OP,0, 0,             32'h0040_0030, 0, 0, 0, 32'h0040_0030, 32'h0040_0020, 0, 32'h0040_1002, 0));
    tbl.push_back(mk(0, 0, J_OP,   0, 32'd8,         0,             1, 0, 0, TV,           32'h0040_0030, 0, 32'h0040_1002, 0));
    tbl.push_back(mk(0, 0, ALU_OP, 0, 0,             0,             0, 1, 0, 32'h0040_0030, 32'h0040_0030, 0, 32'h0040_1002, 0));
    tbl.push_back(mk(0, 0, ALU_OP, 0, 0,             0,             1, 1, 0, TV,           32'h0040_0030, 0, 32'h0040_1002, 0));
    tbl.push_back(mk(0, 0, JALR_OP,0, 0,             32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 32'h0040_0030, 0, 32'h0040_1002, 0));
    tbl.push_back(mk(0, 0, ALU_OP, 0, 0,             0,             0, 0, 0, 32'h0000_0000, 32'h0040_0030, 0, 32'h0040_1002, 0));
    tbl.push_back(mk(0, 0, J_OP,   0, 32'd2,         0,             0, 0, 0, 32'h0000_0000, 32'h0000_0000, 1, 32'h0000_0002, 1));
    tbl.push_back(mk(1, 0, ALU_OP, 0, 0,             0,             0, 0, 0, RV,           0,            0, 0,            0));
    tbl.push_back(mk(0, 0, B_OP,   0, 32'd6,         0,             0, 0, 0, 32'h0040_0004, 0,           0, 0,            0));
    tbl.push_back(mk(0, 0, B_OP,   1, 32'd6,         0,             0, 0, 0, 32'h0040_0004, 32'h0040_0004, 1, 32'h0040_000A, 1));
    tbl.push_back(mk(0, 1, ALU_OP, 0, 0,             0,             0, 0, 1, TV,           32'h0040_0004, 0, 32'h0040_000A, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].op, tbl[i].cj, tbl[i].im, tbl[i].alu,
            tbl[i].tr, tbl[i].mr, tbl[i].ack);
      check_all($sformatf("row%0d", i), tbl[i].e_pc, tbl[i].e_epc, tbl[i].e_f,
                tbl[i].e_fa, tbl[i].e_st);
    end

    // Stalled trap/mret requests are dropped, not remembered.
    drive(1, 0, ALU_OP, 0, 0, 0, 0, 0, 0);
    drive(0, 1, ALU_OP, 0, 0, 0, 1, 0, 0);
    check_all("stall_trap", RV, 0, 0, 0, 0);
    drive(0, 0, ALU_OP, 0, 0, 0, 0, 0, 0);
    check_all("after_stall_trap", RV + 32'd4, 0, 0, 0, 0);
    drive(0, 1, ALU_OP, 0, 0, 0, 0, 1, 0);
    drive(0, 0, ALU_OP, 0, 0, 0, 0, 0, 0);
    check_all("after_stall_mret", RV + 32'd8, 0, 0, 0, 0);

    // Reset while faulted, then fault held across several cycles without ack.
    drive(0, 0, JALR_OP, 0, 0, 32'h0000_0102, 0, 0, 0);
    drive(0, 0, J_OP, 0, 32'd16, 0, 0, 0, 0);
    drive(0, 0, ALU_OP, 0, 0, 0, 0, 0, 0);
    check_all("fault_hold", RV + 32'd8, RV + 32'd8, 1, 32'h0000_0102, 1);
    drive(1, 0, ALU_OP, 0, 0, 0, 0, 0, 1);
    check_all("reset_in_fault", RV, 0, 0, 0, 0);

`ifdef PC_UNIT_PERF_CNT_EN
    check_cnt("cnt_reset", 0, 0, 0);
    for (int k = 0; k < 4; k++) drive(0, 0, B_OP, 1, 32'd8, 0, 0, 0, 0);
    check_cnt("cnt_sat", 3, 3, 0);
    drive(0, 0, JALR_OP, 0, 0, RV, 0, 0, 0);
    check_cnt("cnt_jalr", 3, 3, 1);
    drive(0, 0, JALR_OP, 0, 0, 32'h2, 0, 0, 0);
    check_cnt("cnt_fault_edge", 3, 3, 1);
    drive(0, 0, ALU_OP, 0, 0, 0, 0, 0, 1);
    drive(1, 0, ALU_OP, 0, 0, 0, 0, 0, 0);
    drive(0, 1, B_OP, 1, 32'd8, 0, 0, 0, 0);
    drive(0, 1, B_OP, 1, 32'd8, 0, 0, 0, 0);
    check_cnt("cnt_stall", 0, 0, 0);
`endif

    // Randomised run against the reference model.
    drive(1, 0, ALU_OP, 0, 0, 0, 0, 0, 0);
    model_step(1, 0, ALU_OP, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      r   = ($urandom_range(0, 99) < 2);
      s   = ($urandom_range(0, 99) < 25);
      case ($urandom_range(0, 3))
        0:       op = B_OP;
        1:       op = J_OP;
        2:       op = JALR_OP;
        default: op = 7'($urandom);
      endcase
      cj  = $urandom_range(0, 1) == 1;
      im  = $urandom_range(0, 9) < 8 ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      alu = $urandom_range(0, 9) < 7 ? ($urandom & 32'hFFFF_FFFD) : $urandom;
      tr  = ($urandom_range(0, 99) < 8);
      mr  = ($urandom_range(0, 99) < 8);
      ack = ($urandom_range(0, 99) < 35);
      drive(r, s, op, cj, im, alu, tr, mr, ack);
      model_step(r, s, op, cj, im, alu, tr, mr, ack);
      check_all($sformatf("rnd%0d", n), m_pc, m_epc, m_f, m_fa, m_f ? 2'd1 : 2'd0);
`ifdef PC_UNIT_PERF_CNT_EN
      check_cnt($sformatf("rnd%0d", n), m_tot, m_tkn, m_jmp);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
